mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipelined CPU, directly downstream of the execute stage. It owns the EX/MEM pipeline register, a word-addressed data memory, and branch resolution. It drives the PC-select and flush signals that resolve control hazards for taken branches. Its outputs feed the write-back stage, and its branch outputs feed the fetch stage and the upstream pipeline registers.

## Interface
Parameters:
- DMEM_DEPTH, 32, number of 32-bit data-memory words; must be a power of two.
- AW, 5, word-index width; equals log2(DMEM_DEPTH).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- ex_wreg, ex_m2reg, ex_wmem, ex_branch  in  1 each  control from the execute stage.
- ex_zero  in  1  ALU operands equal (beq condition).
- ex_aluR  in  32  ALU result, used as the load/store byte address.
- ex_inB  in  32  store data.
- ex_pc  in  32  branch target.
- ex_destR  in  5  destination register.
- EXE_ins_type, EXE_ins_number  in  4 each  instruction-tracking tags.
- mem_wreg, mem_m2reg  out  1 each  registered control to write-back.
- mem_aluR  out  32  registered ALU result.
- mem_mdata  out  32  data-memory read data.
- mem_destR  out  5  registered destination register.
- mem_pcsrc  out  1  branch taken; fetch selects mem_bpc.
- mem_bpc  out  32  registered branch target.
- mem_flush  out  1  flush IF/ID and ID/EX; equals mem_pcsrc.
- MEM_ins_type, MEM_ins_number  out  4 each  registered tags.

## Operation
EX/MEM register fields:
- Control fields: wreg, m2reg, wmem, branch, zero.
- Data fields: aluR, inB, pc, destR.
- Tag fields: ins_type, ins_number.

Branch resolution and hazard handling:
- mem_pcsrc = branch & zero, combinational from the registered fields.
- mem_flush = mem_pcsrc.
- Self-squash: on a rising edge where mem_pcsrc=1, the register loads a bubble instead of the ex_* inputs.
  - Bubble: wreg, m2reg, wmem, branch, zero all 0; ins_type = 0, ins_number = 0.
  - Data fields still load ex_* and are don't-care.
- Together with upstream flushing of IF/ID and ID/EX, this discards the three instructions fetched after the branch.

Data memory:
- Index = mem_aluR[AW+1:2]. Bits [1:0] are ignored, and higher bits are ignored, so addresses wrap modulo DMEM_DEPTH words.
- Read is asynchronous: mem_mdata = dmem[index].
- Write is synchronous: at a rising edge with registered wmem=1, dmem[index] <= inB.
- A read of the word being written shows the old value until the edge and the new value after it.
- Load result selection (mem_m2reg ? mem_mdata : mem_aluR) is done in write-back, not here.

Reset:
- clrn=0 immediately clears every register field to 0 and every dmem word to 0.
- Reset value of every output is 0, including mem_mdata, since dmem[0] = 0.
- A store pending in the register when reset asserts is discarded.
- Reset has priority over clock edges.

## Timing
- Latency of 1 cycle: ex_* sampled at edge N appear on mem_* after edge N.
- mem_pcsrc, mem_flush and mem_bpc are valid in the same cycle the branch occupies MEM.
  - Fetch loads mem_bpc at the next edge.
  - The flush takes effect at that same edge.
- Store:
  - The address is in the register during cycle N+1.
  - Memory is updated at edge N+2.
  - A load directly following the store reads the new value, since its address is registered at edge N+2.
- No stall or handshake: the register loads every cycle (or loads a bubble on squash).
- Simultaneous events:
  - A taken branch in MEM and a store in EX: the store is squashed and never writes.
  - Back-to-back branches: the second branch is squashed, so only the first redirects.
- The clrn release is asynchronous. The first capture happens at the first rising edge with clrn=1.

## Test plan
- Reset: hold clrn=0 with random ex_* and clk running; all outputs are 0. Release clrn and apply ex_wreg=1, ex_aluR=0x1234 at one edge; after it mem_wreg=1 and mem_aluR=0x1234.
- Store then load: a store with ex_aluR=0x8, ex_inB=0xDEADBEEF, followed by a load with ex_aluR=0x8 and ex_m2reg=1. In the load's MEM cycle, mem_mdata=0xDEADBEEF and mem_m2reg=1.
- Address wrap: store 0x55 at address 0x80 (word 32, which maps to index 0). A load from 0x0 returns 0x55, and a load from 0x3 also returns 0x55.
- Taken branch: ex_branch=1, ex_zero=1, ex_pc=0x40, followed by a store with ex_wmem=1. In the branch's MEM cycle, mem_pcsrc=1, mem_flush=1 and mem_bpc=0x40. In the next cycle the squashed store shows mem_wreg=0 and MEM_ins_type=0, and the memory is unchanged.
- Untaken branch: ex_branch=1, ex_zero=0. mem_pcsrc stays 0, and the following instruction passes through with its tags intact.
- Reset mid-store: assert clrn=0 while registered wmem=1, before the write edge. The memory word stays 0 and all outputs go to 0 at once.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX -> MEM bundle and MEM -> WB/IF outputs of the memory stage.
// The slave side is the stage itself; the master side drives ex_*.
interface mem_stage_if;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic        ex_wmem;
  logic        ex_branch;
  logic        ex_zero;
  logic [31:0] ex_aluR;
  logic [31:0] ex_inB;
  logic [31:0] ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type;
  logic [3:0]  EXE_ins_number;

  logic        mem_wreg;
  logic        mem_m2reg;
  logic [31:0] mem_aluR;
  logic [31:0] mem_mdata;
  logic [4:0]  mem_destR;
  logic        mem_pcsrc;
  logic [31:0] mem_bpc;
  logic        mem_flush;
  logic [3:0]  MEM_ins_type;
  logic [3:0]  MEM_ins_number;

  modport master (
    output ex_wreg, ex_m2reg, ex_wmem,
    output ex_branch, ex_zero,
    output ex_aluR, ex_inB, ex_pc,
    output ex_destR,
    output EXE_ins_type, EXE_ins_number,
    input  mem_wreg, mem_m2reg,
    input  mem_aluR, mem_mdata,
    input  mem_destR,
    input  mem_pcsrc, mem_bpc, mem_flush,
    input  MEM_ins_type, MEM_ins_number
  );

  modport slave (
    input  ex_wreg, ex_m2reg, ex_wmem,
    input  ex_branch, ex_zero,
    input  ex_aluR, ex_inB, ex_pc,
    input  ex_destR,
    input  EXE_ins_type, EXE_ins_number,
    output mem_wreg, mem_m2reg,
    output mem_aluR, mem_mdata,
    output mem_destR,
    output mem_pcsrc, mem_bpc, mem_flush,
    output MEM_ins_type, MEM_ins_number
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, word data memory and
// branch resolution with self-squash of the slot behind a taken branch.
module mem_stage #(
  parameter int DMEM_DEPTH = 32,
  parameter int AW         = 5
) (
  input logic        clk,
  input logic        clrn,
  mem_stage_if.slave bus
);

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        branch;
    logic        zero;
    logic [31:0] alu_r;
    logic [31:0] in_b;
    logic [31:0] pc;
    logic [4:0]  dest_r;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } ex_mem_t;

  ex_mem_t       ex_mem_q;
  ex_mem_t       ex_mem_d;
  logic [31:0]   dmem_q [DMEM_DEPTH];
  logic [AW-1:0] idx;
  logic          pcsrc;

  assign pcsrc = ex_mem_q.branch & ex_mem_q.zero;
  assign idx   = ex_mem_q.alu_r[AW+1:2];

  // Next EX/MEM contents; a taken branch turns its successor into a bubble.
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.wreg       = bus.ex_wreg;
    ex_mem_d.m2reg      = bus.ex_m2reg;
    ex_mem_d.wmem       = bus.ex_wmem;
    ex_mem_d.branch     = bus.ex_branch;
    ex_mem_d.zero       = bus.ex_zero;
    ex_mem_d.alu_r      = bus.ex_aluR;
    ex_mem_d.in_b       = bus.ex_inB;
    ex_mem_d.pc         = bus.ex_pc;
    ex_mem_d.dest_r     = bus.ex_destR;
    ex_mem_d.ins_type   = bus.EXE_ins_type;
    ex_mem_d.ins_number = bus.EXE_ins_number;
    if (pcsrc) begin
      ex_mem_d.wreg       = 1'b0;
      ex_mem_d.m2reg      = 1'b0;
      ex_mem_d.wmem       = 1'b0;
      ex_mem_d.branch     = 1'b0;
      ex_mem_d.zero       = 1'b0;
      ex_mem_d.ins_type   = '0;
      ex_mem_d.ins_number = '0;
    end
  end

  // EX/MEM pipeline register, loads every cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // Data memory: cleared by reset, written by the store sitting in MEM.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        dmem_q[i] <= '0;
      end
    end else if (ex_mem_q.wmem) begin
      dmem_q[idx] <= ex_mem_q.in_b;
    end
  end

  assign bus.mem_wreg       = ex_mem_q.wreg;
  assign bus.mem_m2reg      = ex_mem_q.m2reg;
  assign bus.mem_aluR       = ex_mem_q.alu_r;
  assign bus.mem_mdata      = dmem_q[idx];
  assign bus.mem_destR      = ex_mem_q.dest_r;
  assign bus.mem_pcsrc      = pcsrc;
  assign bus.mem_bpc        = ex_mem_q.pc;
  assign bus.mem_flush      = pcsrc;
  assign bus.MEM_ins_type   = ex_mem_q.ins_type;
  assign bus.MEM_ins_number = ex_mem_q.ins_number;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: instruction-level model of the
// squash rule and word memory, checked by a separate monitor.
module tb_mem_stage;

  typedef struct {
    int          cap;
    logic        wreg;
    logic        m2reg;
    logic        pcsrc;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] bpc;
    logic [4:0]  dest;
    logic [3:0]  typ;
    logic [3:0]  num;
  } exp_t;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] mm [32];
  bit          prev_taken;

  mem_stage_if bus ();

  mem_stage #(
    .DMEM_DEPTH(32),
    .AW        (5)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, x, $time);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_wreg"},   bus.mem_wreg, 0);
    chk({tag, "_m2reg"},  bus.mem_m2reg, 0);
    chk({tag, "_aluR"},   bus.mem_aluR, 0);
    chk({tag, "_mdata"},  bus.mem_mdata, 0);
    chk({tag, "_destR"},  bus.mem_destR, 0);
    chk({tag, "_pcsrc"},  bus.mem_pcsrc, 0);
    chk({tag, "_bpc"},    bus.mem_bpc, 0);
    chk({tag, "_flush"},  bus.mem_flush, 0);
    chk({tag, "_type"},   bus.MEM_ins_type, 0);
    chk({tag, "_number"}, bus.MEM_ins_number, 0);
  endtask

  task automatic drive_rand();
    bus.ex_wreg        = 1'($urandom);
    bus.ex_m2reg       = 1'($urandom);
    bus.ex_wmem        = 1'($urandom);
    bus.ex_branch      = 1'($urandom);
    bus.ex_zero        = 1'($urandom);
    bus.ex_aluR        = $urandom;
    bus.ex_inB         = $urandom;
    bus.ex_pc          = $urandom;
    bus.ex_destR       = 5'($urandom);
    bus.EXE_ins_type   = 4'($urandom);
    bus.EXE_ins_number = 4'($urandom);
  endtask

  task automatic drive_nop();
    bus.ex_wreg        = 1'b0;
    bus.ex_m2reg       = 1'b0;
    bus.ex_wmem        = 1'b0;
    bus.ex_branch      = 1'b0;
    bus.ex_zero        = 1'b0;
    bus.ex_aluR        = '0;
    bus.ex_inB         = '0;
    bus.ex_pc          = '0;
    bus.ex_destR       = '0;
    bus.EXE_ins_type   = '0;
    bus.EXE_ins_number = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mm[i] = '0;
    prev_taken = 1'b0;
  endtask

  // Issue one instruction into EX and record what MEM must show next cycle.
  task automatic issue(
    input logic        wreg,
    input logic        m2reg,
    input logic        wmem,
    input logic        branch,
    input logic        zero,
    input logic [31:0] alu,
    input logic [31:0] inb,
    input logic [31:0] pc,
    input logic [4:0]  dr,
    input logic [3:0]  ty,
    input logic [3:0]  nm
  );
    exp_t e;
    bit   sq;
    int   w;
    @(posedge clk);
    #1;
    bus.ex_wreg        = wreg;
    bus.ex_m2reg       = m2reg;
    bus.ex_wmem        = wmem;
    bus.ex_branch      = branch;
    bus.ex_zero        = zero;
    bus.ex_aluR        = alu;
    bus.ex_inB         = inb;
    bus.ex_pc          = pc;
    bus.ex_destR       = dr;
    bus.EXE_ins_type   = ty;
    bus.EXE_ins_number = nm;
    sq      = prev_taken;
    w       = int'((alu / 4) % 32);
    e.cap   = edge_cnt + 1;
    e.wreg  = sq ? 1'b0 : wreg;
    e.m2reg = sq ? 1'b0 : m2reg;
    e.pcsrc = !sq && branch && zero;
    e.alu   = alu;
    e.mdata = mm[w];
    e.bpc   = pc;
    e.dest  = dr;
    e.typ   = sq ? 4'd0 : ty;
    e.num   = sq ? 4'd0 : nm;
    if (!sq && wmem) mm[w] = inb;
    prev_taken = e.pcsrc;
    sb.push_back(e);
  endtask

  // Monitor: compare MEM outputs against the oldest captured expectation.
  always @(negedge clk) begin
    if (clrn && sb.size() > 0 && sb[0].cap <= edge_cnt) begin
      me = sb.pop_front();
      chk("wreg",   bus.mem_wreg, me.wreg);
      chk("m2reg",  bus.mem_m2reg, me.m2reg);
      chk("aluR",   bus.mem_aluR, me.alu);
      chk("mdata",  bus.mem_mdata, me.mdata);
      chk("destR",  bus.mem_destR, me.dest);
      chk("pcsrc",  bus.mem_pcsrc, me.pcsrc);
      chk("flush",  bus.mem_flush, me.pcsrc);
      chk("bpc",    bus.mem_bpc, me.bpc);
      chk("type",   bus.MEM_ins_type, me.typ);
      chk("number", bus.MEM_ins_number, me.num);
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    drive_rand();
    #1 clrn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 drive_rand();
      #2 chk_zero("rst");
    end
    drive_nop();
    @(negedge clk);
    clrn = 1'b1;
    model_reset();

    issue(1, 0, 0, 0, 0, 32'h1234, 0, 0, 5'd1, 4'd1, 4'd1);
    issue(0, 0, 1, 0, 0, 32'h8, 32'hDEADBEEF, 0, 0, 4'd2, 4'd2);
    issue(1, 1, 0, 0, 0, 32'h8, 0, 0, 5'd3, 4'd3, 4'd3);
    issue(0, 0, 1, 0, 0, 32'h80, 32'h55, 0, 0, 4'd2, 4'd4);
    issue(1, 1, 0, 0, 0, 32'h0, 0, 0, 5'd4, 4'd3, 4'd5);
    issue(1, 1, 0, 0, 0, 32'h3, 0, 0, 5'd5, 4'd3, 4'd6);
    issue(0, 0, 0, 1, 1, 0, 0, 32'h40, 0, 4'd4, 4'd7);
    issue(0, 0, 1, 0, 0, 32'h8, 32'h12345678, 0, 0, 4'd2, 4'd8);
    issue(1, 1, 0, 0, 0, 32'h8, 0, 0, 5'd6, 4'd3, 4'd9);
    issue(0, 0, 0, 1, 0, 0, 0, 32'h80, 0, 4'd4, 4'd10);
    issue(1, 0, 0, 0, 0, 32'h77, 0, 0, 5'd7, 4'd7, 4'd9);
    issue(0, 0, 0, 1, 1, 0, 0, 32'h100, 0, 4'd4, 4'd11);
    issue(0, 0, 0, 1, 1, 0, 0, 32'h200, 0, 4'd4, 4'd12);
    issue(1, 0, 0, 0, 0, 32'h99, 0, 0, 5'd8, 4'd1, 4'd13);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
      issue(k <= 1, k == 1, k == 2, k == 3, 1'($urandom), a,
            $urandom, $urandom, 5'($urandom), 4'($urandom),
            4'($urandom));
    end
    drain();

    issue(0, 0, 1, 0, 0, 32'h10, 32'hAB, 0, 0, 4'd2, 4'd1);
    @(posedge clk);
    #2 clrn = 1'b0;
    sb.delete();
    #1 chk_zero("midrst");
    @(posedge clk);
    #1 chk_zero("midrst_hold");
    drive_nop();
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    issue(1, 1, 0, 0, 0, 32'h10, 0, 0, 5'd2, 4'd3, 4'd2);
    issue(1, 0, 0, 0, 0, 32'h5, 0, 0, 5'd3, 4'd1, 4'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
